// File: rtl/dmem_bridge_pkg.sv
// Shared types and constants for the data-memory bridge.
package dmem_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int unsigned DEF_TIMEOUT = 255;
  localparam int unsigned CNT_W       = 8;

endpackage

// File: rtl/dmem_bridge_if.sv
// Request/response bus between the bridge (master) and data memory (slave).
interface dmem_bridge_if;
  logic        bus_valid;
  logic        bus_ready;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wmask;
  logic [31:0] bus_wdata;
  logic        bus_rsp_valid;
  logic [31:0] bus_rdata;

  modport master (
    output bus_valid, bus_we, bus_addr, bus_wmask, bus_wdata,
    input  bus_ready, bus_rsp_valid, bus_rdata
  );

  modport slave (
    input  bus_valid, bus_we, bus_addr, bus_wmask, bus_wdata,
    output bus_ready, bus_rsp_valid, bus_rdata
  );
endinterface

// File: rtl/dmem_bridge_wait_counter.sv
// Per-transaction wait counter; stops counting once LIMIT is reached.
module wait_counter
  import dmem_bridge_pkg::*;
#(
  parameter int unsigned LIMIT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic reached
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign reached = (cnt == CNT_W'(LIMIT));

endmodule

// File: rtl/dmem_bridge.sv
// Bridges the core memory stage onto a valid/ready request bus with a
// separate response strobe, stalling the core and aborting on timeout.
module dmem_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          store,
  input  logic [31:0]   addr,
  input  logic [3:0]    mask,
  input  logic [31:0]   store_data,
  output logic          stall,
  output logic [31:0]   load_data,
  output logic          err,
  dmem_bridge_if.master bus
);

  state_t      state, state_nx;
  logic        req;
  logic        reached;
  logic        valid_c;
  logic        take_rsp;
  logic        abort;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wmask_q;

  assign req = load | store;

  wait_counter #(.LIMIT(TIMEOUT)) u_wait_counter (
    .clk     (clk),
    .rst     (rst),
    .clear   ((state == IDLE) && req),
    .enable  (((state == REQ) || (state == RSP)) && !reached),
    .reached (reached)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // A simultaneous load and store is treated as a store.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      wmask_q <= '0;
      wdata_q <= '0;
    end else if ((state == IDLE) && req) begin
      addr_q  <= addr & 32'hFFFF_FFFC;
      we_q    <= store;
      wmask_q <= store ? mask : 4'h0;
      wdata_q <= store ? store_data : 32'h0;
    end
  end

  // load_data and err are only non-zero during the single DONE cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err       <= 1'b0;
      load_data <= '0;
    end else begin
      err       <= abort;
      load_data <= (take_rsp && !we_q) ? bus.bus_rdata : 32'h0;
    end
  end

  // Timeout wins over the bus; valid is withdrawn in the abort cycle so the
  // slave cannot accept a request the bridge is abandoning.
  always_comb begin
    state_nx = state;
    stall    = 1'b0;
    valid_c  = 1'b0;
    take_rsp = 1'b0;
    abort    = 1'b0;
    case (state)
      IDLE: begin
        stall = req;
        if (req) state_nx = REQ;
      end
      REQ: begin
        stall = 1'b1;
        if (reached) begin
          abort    = 1'b1;
          state_nx = DONE;
        end else begin
          valid_c = 1'b1;
          if (bus.bus_ready) state_nx = RSP;
        end
      end
      RSP: begin
        stall = 1'b1;
        if (reached) begin
          abort    = 1'b1;
          state_nx = DONE;
        end else if (bus.bus_rsp_valid) begin
          take_rsp = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign bus.bus_valid = valid_c;
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wmask = wmask_q;
  assign bus.bus_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed testbench for dmem_bridge; inputs change at the falling edge and
// outputs are checked 1 time unit later.
module tb_dmem_bridge;

  logic        clk;
  logic        rst;
  logic        load;
  logic        store;
  logic [31:0] addr;
  logic [3:0]  mask;
  logic [31:0] store_data;
  logic        stall;
  logic [31:0] load_data;
  logic        err;

  int checks;
  int errors;

  dmem_bridge_if bus ();

  dmem_bridge #(.TIMEOUT(255)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .store      (store),
    .addr       (addr),
    .mask       (mask),
    .store_data (store_data),
    .stall      (stall),
    .load_data  (load_data),
    .err        (err),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    load = 1'b0; store = 1'b0; addr = '0; mask = '0; store_data = '0;
    bus.bus_ready = 1'b0; bus.bus_rsp_valid = 1'b0; bus.bus_rdata = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #1 rst = 1'b0;
    load = 1'b1;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL reset_stall_req: got %b expected 1", stall); end
    checks++; if (bus.bus_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.bus_valid); end
    checks++; if ({bus.bus_we, bus.bus_wmask, err} !== 6'b0) begin errors++; $display("FAIL reset_we_wmask_err: got %b expected 0", {bus.bus_we, bus.bus_wmask, err}); end
    checks++; if (load_data !== 32'h0) begin errors++; $display("FAIL reset_load_data: got %h expected 0", load_data); end
    repeat (2) @(negedge clk);
    load = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall_noreq: got %b expected 0", stall); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_min_load();
    @(negedge clk); load = 1'b1; addr = 32'h0000_1006; #1;
    checks++; if ({stall, bus.bus_valid} !== 2'b10) begin errors++; $display("FAIL minload_c0: got %b expected 10", {stall, bus.bus_valid}); end
    @(negedge clk); bus.bus_ready = 1'b1; #1;
    checks++; if ({stall, bus.bus_valid, bus.bus_we, bus.bus_wmask} !== 7'b1100000) begin errors++; $display("FAIL minload_c1_ctrl: got %b expected 1100000", {stall, bus.bus_valid, bus.bus_we, bus.bus_wmask}); end
    checks++; if (bus.bus_addr !== 32'h0000_1004) begin errors++; $display("FAIL minload_addr: got %h expected 00001004", bus.bus_addr); end
    @(negedge clk); bus.bus_ready = 1'b0; bus.bus_rsp_valid = 1'b1; bus.bus_rdata = 32'hDEAD_BEEF; #1;
    checks++; if ({stall, bus.bus_valid} !== 2'b10) begin errors++; $display("FAIL minload_c2: got %b expected 10", {stall, bus.bus_valid}); end
    @(negedge clk); bus.bus_rsp_valid = 1'b0; bus.bus_rdata = '0; load = 1'b0; #1;
    checks++; if ({stall, err} !== 2'b00) begin errors++; $display("FAIL minload_c3_stall: got %b expected 00", {stall, err}); end
    checks++; if (load_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL minload_data: got %h expected deadbeef", load_data); end
    @(negedge clk); #1;
    checks++; if (load_data !== 32'h0) begin errors++; $display("FAIL minload_data_one_cycle: got %h expected 0", load_data); end
  endtask

  task automatic test_store_wait();
    @(negedge clk); store = 1'b1; addr = 32'h0000_2003; mask = 4'b1100; store_data = 32'hABCD_0000; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL store_c0_stall: got %b expected 1", stall); end
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      bus.bus_ready = (c == 4);
      bus.bus_rsp_valid = (c == 2);
      bus.bus_rdata = 32'h9999_9999;
      #1;
      checks++;
      if ({stall, bus.bus_valid, bus.bus_we, bus.bus_wmask, bus.bus_addr, bus.bus_wdata} !== {3'b111, 4'hC, 32'h0000_2000, 32'hABCD_0000}) begin
        errors++;
        $display("FAIL store_hold_c%0d: got %b_%b_%b_%h_%h_%h expected 1_1_1_c_00002000_abcd0000", c, stall, bus.bus_valid, bus.bus_we, bus.bus_wmask, bus.bus_addr, bus.bus_wdata);
      end
    end
    @(negedge clk); bus.bus_ready = 1'b0; bus.bus_rsp_valid = 1'b0; #1;
    checks++; if ({stall, bus.bus_valid} !== 2'b10) begin errors++; $display("FAIL store_rsp_wait: got %b expected 10", {stall, bus.bus_valid}); end
    @(negedge clk); bus.bus_rsp_valid = 1'b1; bus.bus_rdata = 32'h5555_5555; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL store_rsp_cycle: got %b expected 1", stall); end
    @(negedge clk); bus.bus_rsp_valid = 1'b0; store = 1'b0; #1;
    checks++; if ({stall, err, load_data} !== 34'h0) begin errors++; $display("FAIL store_done: got %b_%b_%h expected 0_0_00000000", stall, err, load_data); end
  endtask

  task automatic test_both_and_spurious();
    idle_inputs();
    @(negedge clk); bus.bus_rsp_valid = 1'b1; bus.bus_rdata = 32'hFFFF_FFFF;
    @(negedge clk); #1;
    checks++; if ({stall, bus.bus_valid, load_data} !== 34'h0) begin errors++; $display("FAIL spurious_idle: got %b_%b_%h expected 0_0_00000000", stall, bus.bus_valid, load_data); end
    @(negedge clk); bus.bus_rsp_valid = 1'b0;
    load = 1'b1; store = 1'b1; addr = 32'h0000_0031; mask = 4'hF; store_data = 32'h1234_5678; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL both_c0_stall: got %b expected 1", stall); end
    @(negedge clk); bus.bus_ready = 1'b1; #1;
    checks++; if ({bus.bus_valid, bus.bus_we, bus.bus_wmask, bus.bus_addr} !== {2'b11, 4'hF, 32'h0000_0030}) begin errors++; $display("FAIL both_as_store: got %b_%b_%h_%h expected 1_1_f_00000030", bus.bus_valid, bus.bus_we, bus.bus_wmask, bus.bus_addr); end
    @(negedge clk); bus.bus_ready = 1'b0; bus.bus_rsp_valid = 1'b1; bus.bus_rdata = 32'h7777_7777;
    @(negedge clk); bus.bus_rsp_valid = 1'b0; load = 1'b0; store = 1'b0; #1;
    checks++; if ({stall, load_data} !== 33'h0) begin errors++; $display("FAIL both_done: got %b_%h expected 0_00000000", stall, load_data); end
  endtask

  task automatic test_timeout();
    int bad;
    bad = 0;
    idle_inputs();
    @(negedge clk); load = 1'b1; addr = 32'h0000_0040; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL timeout_c0_stall: got %b expected 1", stall); end
    for (int c = 1; c <= 255; c++) begin
      @(negedge clk); #1;
      if (bus.bus_valid !== 1'b1 || stall !== 1'b1 || err !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL timeout_waiting: got %0d bad cycles expected 0", bad); end
    @(negedge clk); #1;
    checks++; if ({stall, bus.bus_valid, err} !== 3'b100) begin errors++; $display("FAIL timeout_abort_cycle: got %b expected 100", {stall, bus.bus_valid, err}); end
    @(negedge clk); load = 1'b0; #1;
    checks++; if ({stall, bus.bus_valid, err, load_data} !== {3'b001, 32'h0}) begin errors++; $display("FAIL timeout_done: got %b_%b_%b_%h expected 0_0_1_00000000", stall, bus.bus_valid, err, load_data); end
    @(negedge clk); #1;
    checks++; if ({stall, bus.bus_valid, err} !== 3'b000) begin errors++; $display("FAIL timeout_err_pulse: got %b expected 000", {stall, bus.bus_valid, err}); end
  endtask

  task automatic test_reset_in_rsp();
    idle_inputs();
    @(negedge clk); store = 1'b1; addr = 32'h0000_0050; mask = 4'b0011; store_data = 32'h0000_BEEF;
    @(negedge clk); bus.bus_ready = 1'b1; #1;
    checks++; if ({bus.bus_valid, bus.bus_we} !== 2'b11) begin errors++; $display("FAIL rstrsp_req: got %b expected 11", {bus.bus_valid, bus.bus_we}); end
    @(negedge clk); bus.bus_ready = 1'b0; #1;
    checks++; if ({stall, bus.bus_we, bus.bus_wmask} !== 6'b110011) begin errors++; $display("FAIL rstrsp_in_rsp: got %b expected 110011", {stall, bus.bus_we, bus.bus_wmask}); end
    rst = 1'b0; #1;
    checks++; if ({bus.bus_valid, bus.bus_we, bus.bus_wmask, err, load_data} !== 39'h0) begin errors++; $display("FAIL rstrsp_async_clear: got %b_%b_%h_%b_%h expected all zero", bus.bus_valid, bus.bus_we, bus.bus_wmask, err, load_data); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rstrsp_stall_follows_req: got %b expected 1", stall); end
    store = 1'b0; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rstrsp_stall_noreq: got %b expected 0", stall); end
    @(negedge clk); bus.bus_rsp_valid = 1'b1; bus.bus_rdata = 32'h0000_1234;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); #1;
    checks++; if ({stall, bus.bus_valid, load_data} !== 34'h0) begin errors++; $display("FAIL rstrsp_no_stale_rsp: got %b_%b_%h expected 0_0_00000000", stall, bus.bus_valid, load_data); end
    bus.bus_rsp_valid = 1'b0;
    @(negedge clk); load = 1'b1; addr = 32'h0000_0064;
    @(negedge clk); bus.bus_ready = 1'b1; #1;
    checks++; if ({bus.bus_valid, bus.bus_we, bus.bus_addr} !== {2'b10, 32'h0000_0064}) begin errors++; $display("FAIL rstrsp_fresh_req: got %b_%b_%h expected 1_0_00000064", bus.bus_valid, bus.bus_we, bus.bus_addr); end
    @(negedge clk); bus.bus_ready = 1'b0; bus.bus_rsp_valid = 1'b1; bus.bus_rdata = 32'hCAFE_F00D;
    @(negedge clk); bus.bus_rsp_valid = 1'b0; load = 1'b0; #1;
    checks++; if ({stall, load_data} !== {1'b0, 32'hCAFE_F00D}) begin errors++; $display("FAIL rstrsp_fresh_done: got %b_%h expected 0_cafef00d", stall, load_data); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_min_load();
    test_store_wait();
    test_both_and_spurious();
    test_timeout();
    test_reset_in_rsp();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_bridge.md
DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL set the maximum wait cycles per transaction before abort.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 load  input  1  memory-stage load request.
REQ-005 store  input  1  memory-stage store request.
REQ-006 addr  input  32  ALU byte address.
REQ-007 mask  input  4  byte-lane write mask from the memory stage.
REQ-008 store_data  input  32  lane-aligned store data from the memory stage.
REQ-009 stall  output  1  holds the core; inputs SHALL be stable while high.
REQ-010 load_data  output  32  raw bus word, fed to the memory stage's load path.
REQ-011 err  output  1  one-cycle pulse on timeout abort.
REQ-012 bus_valid / bus_ready  output / input  1 / 1  request handshake.
REQ-013 bus_we  output  1  1 = write.
REQ-014 bus_addr  output  32  word address, bits [1:0] forced to 0.
REQ-015 bus_wmask / bus_wdata  output  4 / 32  write lanes and data.
REQ-016 bus_rsp_valid / bus_rdata  input  1 / 32  response strobe and read data; writes also return a response.

Function
REQ-017 FSM states SHALL be IDLE, REQ, RSP, DONE.
REQ-018 IDLE: on load|store, SHALL register addr/mask/store_data/we and go to REQ; stall SHALL be high combinationally in that same cycle.
REQ-019 load&store both high SHALL be treated as a store.
REQ-020 REQ: bus_valid SHALL be 1 with bus_* held constant until bus_ready; on bus_ready go to RSP.
REQ-021 RSP: on bus_rsp_valid, SHALL capture bus_rdata (loads) and go to DONE; rsp_valid in the same cycle as the REQ handshake SHALL be ignored.
REQ-022 DONE: stall SHALL be 0, load_data SHALL show the captured word for exactly this cycle, and the next state SHALL be IDLE.
REQ-023 For stores, load_data in DONE SHALL be 0.
REQ-024 stall SHALL be 1 in REQ and RSP, and in IDLE only when load|store is high.
REQ-025 Minimum latency: request seen at cycle 0 with ready at 1 and rsp at 2 SHALL drop stall at cycle 3.
REQ-026 The wait counter SHALL clear on IDLE->REQ and increment each cycle in REQ/RSP.
REQ-027 When the wait counter reaches TIMEOUT, the FSM SHALL go to DONE with err=1, load_data=0, and bus_valid dropped.
REQ-028 bus_rsp_valid outside RSP SHALL be ignored.
REQ-029 bus_wmask SHALL be 0 for loads.
REQ-030 No new request SHALL be accepted in DONE; the next instruction is sampled in IDLE.

Reset
REQ-031 rst low SHALL immediately force state IDLE, and set bus_valid, bus_we, bus_wmask, err, load_data, and the counter to 0.
REQ-032 stall SHALL equal load|store while in reset.
REQ-033 A transaction interrupted by reset SHALL be dropped, and no response SHALL be consumed after release.

Structure
REQ-034 Package dmem_bridge_pkg SHALL hold the state enum, default TIMEOUT, and the counter width (8).
REQ-035 One sub-module, wait_counter (clear, enable, reached flag), SHALL implement the timeout counting.

Verification
REQ-036 Load 0x0000_1006: ready=1 at c1, rsp with 0xDEAD_BEEF at c2 -> bus_addr=0x0000_1004, bus_we=0, stall 1,1,1,0, load_data=0xDEAD_BEEF at c3.
REQ-037 Store mask=0b1100, data=0xABCD_0000: ready delayed 3 cycles -> bus_* stable throughout, bus_wmask=0xC, stall released 1 cycle after rsp.
REQ-038 Load with no ready for 255 cycles -> err pulses once, load_data=0, bus_valid=0, FSM returns to IDLE.
REQ-039 load=store=1 -> bus_we=1; spurious rsp_valid while IDLE -> no state change.
REQ-040 rst asserted in RSP -> outputs cleared asynchronously; after release a fresh load completes normally.
